// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch queue.
// Entry layout, FSM encoding and the sequential PC increment.
package fetch_pkg;

    localparam int FQ_XLEN = 32;

    localparam logic [FQ_XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fq_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries with a flush input.
// Head is read combinationally; clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_push  = push && !clear;
        do_pop   = pop && !clear && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Full-and-popping writes the slot being read; the read sees the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, redirect flush.
// Optional FETCHQ_BYPASS_EN forwards a response straight to decode when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    fq_state_t        state_q;
    fq_state_t        state_d;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] fetch_pc_d;
    logic [CW-1:0]    outst_q;
    logic [CW-1:0]    outst_d;
    logic [WIDTH-1:0] last_instr_q;
    logic [WIDTH-1:0] last_instr_d;
    logic [WIDTH-1:0] last_pc_q;
    logic [WIDTH-1:0] last_pc_d;

    logic [CW-1:0]    occ;
    logic [CW:0]      credit;
    logic             can_issue;
    logic             req_fire;
    logic             resp_live;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] inflight_pc;
    logic [WIDTH-1:0] cur_instr;
    logic [WIDTH-1:0] cur_pc;
    fq_entry_t        push_data;
    fq_entry_t        head;

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (occ)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid && (outst_d != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        credit         = {1'b0, occ} + {1'b0, outst_q};
        can_issue      = credit < DEPTH_W;
        imem_req_valid = (state_q == FETCH) && can_issue && !redirect_valid;
        resp_live      = imem_resp_valid && (state_q == FETCH)
                         && !redirect_valid;
    end

    assign imem_req_addr = fetch_pc_q;
    assign req_fire      = imem_req_valid && imem_req_ready;

    // In FETCH every in-flight request is sequential and ends at fetch_pc-4.
    assign inflight_pc = fetch_pc_q - (WIDTH'(outst_q) << 2);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
        if (req_fire && !(imem_resp_valid && (outst_q != '0))) begin
            outst_d = outst_q + 1'b1;
        end else if (!req_fire && imem_resp_valid && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
        end
    end

`ifdef FETCHQ_BYPASS_EN
    assign bypass = resp_live && (occ == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        push_data       = '0;
        push_data.instr = imem_resp_data;
        push_data.pc    = inflight_pc;
        push            = resp_live && !(bypass && out_ready);
        pop             = (occ != '0) && out_ready && !redirect_valid;
    end

    // Decode side; hold the last presented entry while nothing is valid.
    always_comb begin
        out_valid    = (occ != '0) || bypass;
        cur_instr    = bypass ? imem_resp_data : head.instr;
        cur_pc       = bypass ? inflight_pc : head.pc;
        last_instr_d = last_instr_q;
        last_pc_d    = last_pc_q;
        if (out_valid) begin
            last_instr_d = cur_instr;
            last_pc_d    = cur_pc;
        end
        out_instr    = out_valid ? cur_instr : last_instr_q;
        out_pc       = out_valid ? cur_pc : last_pc_q;
        out_pc_plus4 = out_pc + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            last_instr_q <= last_instr_d;
            last_pc_q    <= last_pc_d;
        end
    end

endmodule
